pcie_rx_avst_sink: RTL and testbench

Single-clock FIM-side sink for the PCIe RX Avalon-ST stream after clock crossing. Accepts beats under a fixed ready latency and absorbs in-flight beats in a skid FIFO. Converts AVST framing (sop/eop/empty) to an AXI-S TLP stream (tlast/tkeep/tuser) for the FIM RX path. Optionally checks sop/eop framing and drops malformed beats.

---
 rtl/pcie_rx_avst_sink.sv | 192 +++++++++++++++++++
 tb/tb_pcie_rx_avst_sink.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_rx_avst_sink.sv
// pcie_rx_avst_sink: PCIe RX Avalon-ST to AXI-S TLP sink with skid FIFO.
// Accepts beats under a fixed ready latency, converts sop/eop/empty to
// tuser/tlast/tkeep. Optional sop/eop framing check enabled by defining
// PCIE_RX_SINK_FRAME_CHECK_EN.
module pcie_rx_avst_sink #(
  parameter int unsigned DATA_W        = 256,
  parameter int unsigned READY_LATENCY = 3,
  parameter int unsigned DEPTH         = 8,
  localparam int unsigned NDW          = DATA_W / 32,
  localparam int unsigned EMPTY_W      = $clog2(NDW)
) (
  input  logic               fim_clk,
  input  logic               fim_rst,
  input  logic               avl_rx_valid,
  input  logic               avl_rx_sop,
  input  logic               avl_rx_eop,
  input  logic [EMPTY_W-1:0] avl_rx_empty,
  input  logic [DATA_W-1:0]  avl_rx_data,
  output logic               avl_rx_ready,
  output logic               axis_tvalid,
  input  logic               axis_tready,
  output logic [DATA_W-1:0]  axis_tdata,
  output logic [NDW-1:0]     axis_tkeep,
  output logic               axis_tlast,
  output logic               axis_tuser,
  output logic               err_no_sop,
  output logic               err_no_eop,
  output logic               err_overflow,
  output logic [15:0]        drop_cnt
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  // Beats still in flight after ready drops must always fit.
  if (DEPTH < READY_LATENCY + 4) begin : g_depth_chk
    $error("pcie_rx_avst_sink: DEPTH must be at least READY_LATENCY+4");
  end

  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [NDW-1:0]    r_mem_keep [DEPTH];
  logic              r_mem_sop  [DEPTH];
  logic              r_mem_eop  [DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ready, r_tvalid, r_tlast, r_tuser;
  logic [DATA_W-1:0] r_tdata;
  logic [NDW-1:0]    r_tkeep;
  logic              r_err_no_sop, r_err_no_eop, r_err_overflow;
  logic [15:0]       r_drop_cnt;

  logic              w_valid, w_pop, w_ovf, w_accept, w_push, w_drop, w_head_in;
  logic              w_frame_drop, w_no_sop, w_no_eop;
  logic [NDW-1:0]    w_keep;
  logic [CNT_W-1:0]  w_count_next;
  logic [PTR_W-1:0]  w_rd_next;

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_valid   = avl_rx_valid && !fim_rst;
  assign w_pop     = r_tvalid && axis_tready;
  assign w_ovf     = w_valid && (r_count == CNT_W'(DEPTH)) && !w_pop;
  assign w_accept  = w_valid && !w_ovf;
  assign w_push    = w_accept && !w_frame_drop;
  assign w_drop    = w_ovf || w_frame_drop;
  assign w_keep    = avl_rx_eop ? ({NDW{1'b1}} >> avl_rx_empty) : {NDW{1'b1}};
  assign w_rd_next = w_pop ? f_inc(r_rd_ptr) : r_rd_ptr;
  // Pushed beat becomes the new head when the FIFO is otherwise empty.
  assign w_head_in = w_push && (r_count == CNT_W'(w_pop));

`ifdef PCIE_RX_SINK_FRAME_CHECK_EN
  typedef enum logic {S_IDLE, S_IN_PKT} state_t;
  state_t r_state, w_state_next;

  // Framing state register.
  always_ff @(posedge fim_clk) begin
    if (fim_rst) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Framing next-state and drop/error decode on accepted beats.
  always_comb begin
    w_state_next = r_state;
    w_frame_drop = 1'b0;
    w_no_sop     = 1'b0;
    w_no_eop     = 1'b0;
    if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          if (avl_rx_sop) begin
            if (!avl_rx_eop) w_state_next = S_IN_PKT;
          end else begin
            w_frame_drop = 1'b1;
            w_no_sop     = 1'b1;
          end
        end
        S_IN_PKT: begin
          w_no_eop = avl_rx_sop;
          if (avl_rx_eop) w_state_next = S_IDLE;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end
`else
  assign w_frame_drop = 1'b0;
  assign w_no_sop     = 1'b0;
  assign w_no_eop     = 1'b0;
`endif

  // Post-push/pop occupancy.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // FIFO storage write; no reset needed, pointers define validity.
  always_ff @(posedge fim_clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= avl_rx_data;
      r_mem_keep[r_wr_ptr] <= w_keep;
      r_mem_sop[r_wr_ptr]  <= avl_rx_sop;
      r_mem_eop[r_wr_ptr]  <= avl_rx_eop;
    end
  end

  // Pointers, occupancy, ready and registered AXI-S head.
  always_ff @(posedge fim_clk) begin
    if (fim_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tlast  <= 1'b0;
      r_tuser  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_ready  <= (w_count_next <= CNT_W'(DEPTH - READY_LATENCY - 2));
      r_tvalid <= (w_count_next != '0);
      if (w_head_in) begin
        r_tdata <= avl_rx_data;
        r_tkeep <= w_keep;
        r_tlast <= avl_rx_eop;
        r_tuser <= avl_rx_sop;
      end else if (w_count_next != '0) begin
        r_tdata <= r_mem_data[w_rd_next];
        r_tkeep <= r_mem_keep[w_rd_next];
        r_tlast <= r_mem_eop[w_rd_next];
        r_tuser <= r_mem_sop[w_rd_next];
      end
    end
  end

  // Error pulses, sticky overflow and saturating drop counter.
  always_ff @(posedge fim_clk) begin
    if (fim_rst) begin
      r_err_no_sop   <= 1'b0;
      r_err_no_eop   <= 1'b0;
      r_err_overflow <= 1'b0;
      r_drop_cnt     <= '0;
    end else begin
      r_err_no_sop <= w_no_sop;
      r_err_no_eop <= w_no_eop;
      if (w_ovf) r_err_overflow <= 1'b1;
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign avl_rx_ready = r_ready;
  assign axis_tvalid  = r_tvalid;
  assign axis_tdata   = r_tdata;
  assign axis_tkeep   = r_tkeep;
  assign axis_tlast   = r_tlast;
  assign axis_tuser   = r_tuser;
  assign err_no_sop   = r_err_no_sop;
  assign err_no_eop   = r_err_no_eop;
  assign err_overflow = r_err_overflow;
  assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_pcie_rx_avst_sink.sv
// Scoreboard bench for pcie_rx_avst_sink (default parameters).
// Framing expectations follow PCIE_RX_SINK_FRAME_CHECK_EN.
module tb_pcie_rx_avst_sink;
  localparam int unsigned DATA_W = 256;
  localparam int unsigned NDW    = 8;
  localparam int unsigned EW     = 3;

`ifdef PCIE_RX_SINK_FRAME_CHECK_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif

  logic              fim_clk = 1'b0;
  logic              fim_rst = 1'b1;
  logic              avl_rx_valid = 1'b0, avl_rx_sop = 1'b0, avl_rx_eop = 1'b0;
  logic [EW-1:0]     avl_rx_empty = '0;
  logic [DATA_W-1:0] avl_rx_data = '0;
  logic              avl_rx_ready;
  logic              axis_tvalid, axis_tlast, axis_tuser;
  logic              axis_tready = 1'b0;
  logic [DATA_W-1:0] axis_tdata;
  logic [NDW-1:0]    axis_tkeep;
  logic              err_no_sop, err_no_eop, err_overflow;
  logic [15:0]       drop_cnt;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [NDW-1:0]    k;
    logic              l;
    logic              u;
  } beat_t;

  beat_t exp_q[$];
  beat_t m_exp;
  int    n_checks = 0;
  int    n_fail   = 0;

  pcie_rx_avst_sink dut (
    .fim_clk(fim_clk), .fim_rst(fim_rst),
    .avl_rx_valid(avl_rx_valid), .avl_rx_sop(avl_rx_sop), .avl_rx_eop(avl_rx_eop),
    .avl_rx_empty(avl_rx_empty), .avl_rx_data(avl_rx_data), .avl_rx_ready(avl_rx_ready),
    .axis_tvalid(axis_tvalid), .axis_tready(axis_tready), .axis_tdata(axis_tdata),
    .axis_tkeep(axis_tkeep), .axis_tlast(axis_tlast), .axis_tuser(axis_tuser),
    .err_no_sop(err_no_sop), .err_no_eop(err_no_eop), .err_overflow(err_overflow),
    .drop_cnt(drop_cnt)
  );

  always #5 fim_clk = ~fim_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk(input int k);
    return {NDW{32'hC0DE0000 + 32'(k)}};
  endfunction

  function automatic logic [NDW-1:0] kmodel(input logic eop, input int empty);
    logic [NDW-1:0] k;
    for (int i = 0; i < int'(NDW); i++) k[i] = !eop || (i < int'(NDW) - empty);
    return k;
  endfunction

  // Set the AVST inputs for the current cycle; queue expected beat if kept.
  task automatic put(input logic sop, input logic eop, input int empty, input int k,
                     input logic keep_it);
    beat_t e;
    avl_rx_valid = 1'b1;
    avl_rx_sop   = sop;
    avl_rx_eop   = eop;
    avl_rx_empty = EW'(empty);
    avl_rx_data  = mk(k);
    if (keep_it) begin
      e.d = mk(k);
      e.k = kmodel(eop, empty);
      e.l = eop;
      e.u = sop;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive(input logic sop, input logic eop, input int empty, input int k,
                       input logic keep_it);
    @(posedge fim_clk); #1;
    put(sop, eop, empty, k, keep_it);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge fim_clk); #1;
      avl_rx_valid = 1'b0;
      avl_rx_sop   = 1'b0;
      avl_rx_eop   = 1'b0;
    end
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge fim_clk); #1;
    end
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every accepted AXI-S beat must match the scoreboard head.
  always @(negedge fim_clk) begin
    if (axis_tvalid && axis_tready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got beat d=%h last=%0b user=%0b, required no beat",
                 axis_tdata[31:0], axis_tlast, axis_tuser);
      end else begin
        m_exp = exp_q.pop_front();
        if ({axis_tdata, axis_tkeep, axis_tlast, axis_tuser} !== m_exp) begin
          n_fail++;
          $display("FAIL sb_beat: got d=%h k=%h l=%0b u=%0b, required d=%h k=%h l=%0b u=%0b",
                   axis_tdata[31:0], axis_tkeep, axis_tlast, axis_tuser,
                   m_exp.d[31:0], m_exp.k, m_exp.l, m_exp.u);
        end
      end
    end
  end

  initial begin
    logic h0, h1, h2, allow;
    int   sent, occ, fall_occ, stall_occ;
    bit   fell;

    // Reset: valid presented during reset must be ignored.
    put(1'b1, 1'b1, 0, 1, 1'b0);
    idle(0);
    repeat (3) @(posedge fim_clk);
    #1;
    chk("rst_ready", 32'(avl_rx_ready), 32'd0);
    chk("rst_tvalid", 32'(axis_tvalid), 32'd0);
    chk("rst_tdata", axis_tdata[31:0], 32'd0);
    chk("rst_tkeep_last_user", {axis_tkeep, axis_tlast, axis_tuser}, 32'd0);
    chk("rst_errs", {err_no_sop, err_no_eop, err_overflow}, 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    fim_rst = 1'b0;
    avl_rx_valid = 1'b0;
    @(posedge fim_clk); #1;
    chk("ready_after_rst", 32'(avl_rx_ready), 32'd1);
    chk("tvalid_after_rst", 32'(axis_tvalid), 32'd0);
    idle(2);

    // Single-beat TLP, empty=5: tkeep 8'h07, one cycle latency.
    axis_tready = 1'b1;
    drive(1'b1, 1'b1, 5, 10, 1'b1);
    chk("t1_no_bypass", 32'(axis_tvalid), 32'd0);
    idle(1);
    chk("t1_tvalid", 32'(axis_tvalid), 32'd1);
    chk("t1_tkeep", 32'(axis_tkeep), 32'h07);
    chk("t1_tlast_tuser", {axis_tlast, axis_tuser}, 32'h3);
    idle(1);
    drain("t1_drain");
    idle(4);

    // 20-beat packet, tready low, source honours RL=3.
    axis_tready = 1'b0;
    h0 = 1'b1; h1 = 1'b1; h2 = 1'b1;
    sent = 0; occ = 0; fell = 1'b0; fall_occ = -1; stall_occ = -1;
    for (int c = 0; c < 300 && sent < 20; c++) begin
      @(posedge fim_clk); #1;
      if (c == 12) begin
        stall_occ   = occ;
        axis_tready = 1'b1;
      end
      if (c < 12 && !avl_rx_ready && !fell) begin
        fell     = 1'b1;
        fall_occ = occ;
      end
      allow = h2; h2 = h1; h1 = h0; h0 = avl_rx_ready;
      if (allow) begin
        put(sent == 0, sent == 19, 0, 100 + sent, 1'b1);
        sent++;
        if (c < 12) occ++;
      end else begin
        avl_rx_valid = 1'b0;
      end
    end
    idle(1);
    chk("t2_sent", 32'(sent), 32'd20);
    chk("t2_ready_fall_occ", 32'(fall_occ), 32'd4);
    chk("t2_stall_occ", 32'(stall_occ), 32'd7);
    drain("t2_drain");
    chk("t2_no_overflow", 32'(err_overflow), 32'd0);
    idle(3);

    // Source ignores ready: 10 beats into a stalled 8-deep FIFO.
    axis_tready = 1'b0;
    for (int k = 0; k < 10; k++)
      drive(k == 0 || k >= 8, k == 7 || k >= 8, 0, 200 + k, k < 8);
    idle(1);
    chk("t3_overflow", 32'(err_overflow), 32'd1);
    chk("t3_drop_cnt", 32'(drop_cnt), 32'd2);
    chk("t3_ready_full", 32'(avl_rx_ready), 32'd0);
    axis_tready = 1'b1;
    drain("t3_drain");
    idle(2);

    // Reset mid-packet after 2 beats; partial packet lost.
    axis_tready = 1'b0;
    drive(1'b1, 1'b0, 0, 300, 1'b0);
    drive(1'b0, 1'b0, 0, 301, 1'b0);
    @(posedge fim_clk); #1;
    avl_rx_valid = 1'b0;
    fim_rst = 1'b1;
    @(posedge fim_clk); #1;
    chk("t6_rst_tvalid", 32'(axis_tvalid), 32'd0);
    chk("t6_rst_ready", 32'(avl_rx_ready), 32'd0);
    chk("t6_rst_overflow", 32'(err_overflow), 32'd0);
    chk("t6_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    fim_rst = 1'b0;
    idle(3);
    axis_tready = 1'b1;
    drive(1'b1, 1'b0, 0, 310, 1'b1);
    drive(1'b0, 1'b1, 3, 311, 1'b1);
    idle(1);
    drain("t6_drain");
    idle(2);

    // Beat without sop while idle.
    drive(1'b0, 1'b1, 0, 400, !FC);
    idle(1);
    chk("t4_err_no_sop", 32'(err_no_sop), 32'(FC));
    chk("t4_drop_cnt", 32'(drop_cnt), 32'(FC));
    idle(1);
    chk("t4_no_sop_pulse_end", 32'(err_no_sop), 32'd0);
    drain("t4_drain");
    idle(2);

    // sop inside open packet: restarts packet, tuser on new beat.
    drive(1'b1, 1'b0, 0, 500, 1'b1);
    drive(1'b1, 1'b0, 0, 501, 1'b1);
    drive(1'b0, 1'b1, 2, 502, 1'b1);
    chk("t5_err_no_eop", 32'(err_no_eop), 32'(FC));
    idle(1);
    chk("t5_no_eop_pulse_end", 32'(err_no_eop), 32'd0);
    drain("t5_drain");
    chk("t5_drop_cnt", 32'(drop_cnt), 32'(FC));
    idle(3);

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
